// File: rtl/sensor_frontend_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sensor_frontend_pkg
// Purpose  : Shared constants, types and helpers for the sensor front end.
// Revision : 1.0 - initial release
// ============================================================================
package sensor_frontend_pkg;

    localparam int c_debounce_cycles = 8;
    localparam int c_num_channels    = 4;
    localparam int c_db_cnt_w        = 8;

    localparam int c_temp_w          = 7;
    localparam int c_avg_depth       = 4;
    localparam int c_avg_shift       = $clog2(c_avg_depth);
    localparam int c_smp_cnt_w       = $clog2(c_avg_depth);
    // 4 x 127 = 508 fits in 9 bits, so the running sum never wraps
    localparam int c_acc_w           = 9;

    typedef logic [c_temp_w-1:0]    temp_t;
    typedef logic [c_acc_w-1:0]     acc_t;
    typedef logic [c_db_cnt_w-1:0]  db_cnt_t;
    typedef logic [c_smp_cnt_w-1:0] smp_cnt_t;

    localparam temp_t c_temp_init = 7'd20;

    function automatic temp_t avg_of(input acc_t sum);
        return temp_t'(sum >> c_avg_shift);
    endfunction

endpackage : sensor_frontend_pkg
`default_nettype wire

// File: rtl/sensor_frontend_debounce_cell.sv
`default_nettype none
// ============================================================================
// Module   : debounce_cell
// Purpose  : Two-flop synchroniser followed by a hold-time debouncer.
// Revision : 1.0 - initial release
// ============================================================================
module debounce_cell
    import sensor_frontend_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = c_debounce_cycles
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic level
);

    localparam db_cnt_t c_last = db_cnt_t'(DEBOUNCE_CYCLES - 1);

    logic    r_sync1;
    logic    r_sync2;
    logic    r_stable;
    db_cnt_t r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1  <= 1'b0;
            r_sync2  <= 1'b0;
            r_stable <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_sync1 <= raw;
            r_sync2 <= r_sync1;
            // Any return to the stable level restarts the hold window
            if (r_sync2 != r_stable) begin
                if (r_cnt == c_last) begin
                    r_stable <= r_sync2;
                    r_cnt    <= '0;
                end else begin
                    r_cnt <= r_cnt + db_cnt_t'(1);
                end
            end else begin
                r_cnt <= '0;
            end
        end
    end

    assign level = r_stable;

endmodule : debounce_cell
`default_nettype wire

// File: rtl/sensor_frontend.sv
`default_nettype none
// ============================================================================
// Module   : sensor_frontend
// Purpose  : Debounces four contact sensors and averages temperature samples.
// Revision : 1.0 - initial release
// ============================================================================
module sensor_frontend
    import sensor_frontend_pkg::*;
#(
    parameter int    DEBOUNCE_CYCLES = c_debounce_cycles,
    parameter temp_t TEMP_INIT       = c_temp_init
) (
    input  logic                clk,
    input  logic                Rst_n,
    input  logic                raw_SFD,
    input  logic                raw_SRD,
    input  logic                raw_SW,
    input  logic                raw_SFA,
    input  logic [c_temp_w-1:0] T_raw,
    input  logic                T_valid,
    output logic                SFD,
    output logic                SRD,
    output logic                SW,
    output logic                SFA,
    output logic [c_temp_w-1:0] ST,
    output logic                temp_upd
);

    localparam smp_cnt_t c_last_sample = smp_cnt_t'(c_avg_depth - 1);

    logic [c_num_channels-1:0] w_raw;
    logic [c_num_channels-1:0] w_level;

    assign w_raw = {raw_SFA, raw_SW, raw_SRD, raw_SFD};

    for (genvar i = 0; i < c_num_channels; i++) begin : g_debounce
        debounce_cell #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_cell (
            .clk   (clk),
            .rst_n (Rst_n),
            .raw   (w_raw[i]),
            .level (w_level[i])
        );
    end

    assign SFD = w_level[0];
    assign SRD = w_level[1];
    assign SW  = w_level[2];
    assign SFA = w_level[3];

    acc_t     r_acc;
    smp_cnt_t r_cnt;
    temp_t    r_st;
    logic     r_upd;
    acc_t     w_sum;

    // The final sample is folded in directly so the update lands one edge after it
    assign w_sum = r_acc + acc_t'(T_raw);

    always_ff @(posedge clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_acc <= '0;
            r_cnt <= '0;
            r_st  <= TEMP_INIT;
            r_upd <= 1'b0;
        end else begin
            r_upd <= 1'b0;
            if (T_valid) begin
                if (r_cnt == c_last_sample) begin
                    r_st  <= avg_of(w_sum);
                    r_upd <= 1'b1;
                    r_acc <= '0;
                    r_cnt <= '0;
                end else begin
                    r_acc <= w_sum;
                    r_cnt <= r_cnt + smp_cnt_t'(1);
                end
            end
        end
    end

    assign ST       = r_st;
    assign temp_upd = r_upd;

endmodule : sensor_frontend
`default_nettype wire

// File: tb/tb_sensor_frontend.sv
`default_nettype none
// ============================================================================
// Module   : tb_sensor_frontend
// Purpose  : Directed self-checking bench for sensor_frontend.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sensor_frontend;

    logic       clk;
    logic       Rst_n;
    logic       raw_SFD, raw_SRD, raw_SW, raw_SFA;
    logic [6:0] T_raw;
    logic       T_valid;
    logic       SFD, SRD, SW, SFA;
    logic [6:0] ST;
    logic       temp_upd;

    int n_cmp  = 0;
    int n_fail = 0;

    sensor_frontend dut (
        .clk      (clk),
        .Rst_n    (Rst_n),
        .raw_SFD  (raw_SFD),
        .raw_SRD  (raw_SRD),
        .raw_SW   (raw_SW),
        .raw_SFA  (raw_SFA),
        .T_raw    (T_raw),
        .T_valid  (T_valid),
        .SFD      (SFD),
        .SRD      (SRD),
        .SW       (SW),
        .SFA      (SFA),
        .ST       (ST),
        .temp_upd (temp_upd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_contacts(input string tag, input logic [3:0] exp);
        chk(tag, {28'd0, SFA, SW, SRD, SFD}, {28'd0, exp});
    endtask

    task automatic strobe(input logic [6:0] val);
        T_raw   = val;
        T_valid = 1'b1;
        tick();
        T_valid = 1'b0;
        T_raw   = 7'd99;
    endtask

    initial begin
        Rst_n = 1'b0;
        {raw_SFA, raw_SW, raw_SRD, raw_SFD} = 4'b0000;
        T_raw   = 7'd0;
        T_valid = 1'b0;
        tick();
        tick();
        chk_contacts("reset_contacts", 4'b0000);
        chk("reset_st", {25'd0, ST}, 32'd20);
        chk("reset_upd", {31'd0, temp_upd}, 32'd0);
        Rst_n = 1'b1;
        tick();
        tick();

        // Front door: held rise appears at edge n+9
        raw_SFD = 1'b1;
        for (int k = 0; k <= 8; k++) begin
            tick();
            chk($sformatf("sfd_hold_e%0d", k), {31'd0, SFD}, 32'd0);
        end
        tick();
        chk("sfd_rise_e9", {31'd0, SFD}, 32'd1);
        raw_SFD = 1'b0;
        repeat (12) tick();
        chk("sfd_fall", {31'd0, SFD}, 32'd0);

        // Window: 5-cycle glitch rejected, then 12-cycle hold accepted
        raw_SW = 1'b1;
        repeat (5) tick();
        raw_SW = 1'b0;
        for (int k = 0; k < 16; k++) begin
            tick();
            chk($sformatf("sw_glitch_%0d", k), {31'd0, SW}, 32'd0);
        end
        raw_SW = 1'b1;
        for (int k = 0; k <= 8; k++) begin
            tick();
            chk($sformatf("sw_hold_e%0d", k), {31'd0, SW}, 32'd0);
        end
        tick();
        chk("sw_rise_e9", {31'd0, SW}, 32'd1);
        tick();
        tick();
        chk("sw_high_12", {31'd0, SW}, 32'd1);
        raw_SW = 1'b0;
        repeat (12) tick();
        chk("sw_fall", {31'd0, SW}, 32'd0);

        // Fire alarm: a 7-cycle pulse is one short of acceptance
        raw_SFA = 1'b1;
        repeat (7) tick();
        raw_SFA = 1'b0;
        for (int k = 0; k < 12; k++) begin
            tick();
            chk($sformatf("sfa_7pulse_%0d", k), {31'd0, SFA}, 32'd0);
        end

        // Simultaneous SFA/SRD rise with a 3-cycle SFD glitch
        raw_SFA = 1'b1;
        raw_SRD = 1'b1;
        raw_SFD = 1'b1;
        for (int k = 0; k <= 8; k++) begin
            tick();
            if (k == 2) raw_SFD = 1'b0;
            chk_contacts($sformatf("multi_hold_e%0d", k), 4'b0000);
        end
        tick();
        chk_contacts("multi_rise_e9", 4'b1010);
        repeat (6) tick();
        chk_contacts("multi_settled", 4'b1010);

        // Temperature: 20,21,22,25 -> 22
        strobe(7'd20);
        chk("t1_upd", {31'd0, temp_upd}, 32'd0);
        strobe(7'd21);
        strobe(7'd22);
        chk("t3_upd", {31'd0, temp_upd}, 32'd0);
        chk("t3_st", {25'd0, ST}, 32'd20);
        strobe(7'd25);
        chk("t4_st", {25'd0, ST}, 32'd22);
        chk("t4_upd", {31'd0, temp_upd}, 32'd1);
        tick();
        chk("t4_upd_drop", {31'd0, temp_upd}, 32'd0);
        chk("t4_hold", {25'd0, ST}, 32'd22);
        repeat (3) tick();
        chk("idle_hold", {25'd0, ST}, 32'd22);

        // Full-scale samples with an idle gap carrying garbage
        strobe(7'd127);
        tick();
        strobe(7'd127);
        strobe(7'd127);
        chk("max_st_pre", {25'd0, ST}, 32'd22);
        strobe(7'd127);
        chk("max_st", {25'd0, ST}, 32'd127);
        chk("max_upd", {31'd0, temp_upd}, 32'd1);
        tick();
        chk("max_upd_drop", {31'd0, temp_upd}, 32'd0);

        // Reset mid-average discards the partial sum
        strobe(7'd30);
        strobe(7'd30);
        strobe(7'd30);
        #2;
        Rst_n = 1'b0;
        #1;
        chk("midavg_rst_st", {25'd0, ST}, 32'd20);
        tick();
        tick();
        chk("midavg_in_rst", {25'd0, ST}, 32'd20);
        Rst_n = 1'b1;
        tick();
        chk("midavg_after", {25'd0, ST}, 32'd20);
        strobe(7'd40);
        strobe(7'd40);
        strobe(7'd40);
        chk("post_rst_3", {25'd0, ST}, 32'd20);
        chk("post_rst_3_upd", {31'd0, temp_upd}, 32'd0);
        strobe(7'd40);
        chk("post_rst_st", {25'd0, ST}, 32'd40);
        chk("post_rst_upd", {31'd0, temp_upd}, 32'd1);

        // Asynchronous reset between edges with all contacts high
        {raw_SFA, raw_SW, raw_SRD, raw_SFD} = 4'b1111;
        repeat (14) tick();
        chk_contacts("all_high", 4'b1111);
        #2;
        Rst_n = 1'b0;
        #1;
        chk_contacts("async_rst_contacts", 4'b0000);
        chk("async_rst_st", {25'd0, ST}, 32'd20);
        chk("async_rst_upd", {31'd0, temp_upd}, 32'd0);
        tick();
        Rst_n = 1'b1;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule : tb_sensor_frontend
`default_nettype wire

// File: doc/sensor_frontend.md
SENSOR_FRONTEND -- requirements
Module: sensor_frontend

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 8, SHALL set the number of consecutive cycles a binary sensor must hold a new level before it is accepted (legal 2..255).
REQ-002 Parameter TEMP_INIT, default 7'd20, SHALL set the reset value of ST.
REQ-003 clk  input  1  single clock for all state.
REQ-004 Rst_n  input  1  reset: asynchronous assert, active-low.
REQ-005 raw_SFD, raw_SRD, raw_SW, raw_SFA  input  1 each  unsynchronised front-door, rear-door, window and fire-alarm contacts.
REQ-006 T_raw  input  7  unsigned temperature sample, synchronous to clk.
REQ-007 T_valid  input  1  one-cycle strobe qualifying T_raw.
REQ-008 SFD, SRD, SW, SFA  output  1 each  debounced sensor levels that feed the home-control FSM.
REQ-009 ST  output  7  filtered temperature that feeds the home-control FSM.
REQ-010 temp_upd  output  1  one-cycle pulse when ST is updated.

Function
REQ-011 Each raw_* input SHALL pass through a 2-flop synchroniser before debouncing.
REQ-012 Each channel SHALL keep a stable level and an 8-bit counter; while the synchronised value equals the stable level, the counter SHALL be 0.
REQ-013 While the synchronised value differs from the stable level, the counter SHALL increment each cycle. When the counter equals DEBOUNCE_CYCLES-1 and the values still differ, the stable level SHALL take the synchronised value and the counter SHALL clear.
REQ-014 Latency: a raw change first sampled at edge n and held SHALL appear on the output at edge n+1+DEBOUNCE_CYCLES (edge n+9 at default).
REQ-015 A raw pulse shorter than DEBOUNCE_CYCLES cycles after synchronisation SHALL NOT change the output. A return to the stable level SHALL clear the counter.
REQ-016 The four channels SHALL be fully independent. Simultaneous changes on several channels SHALL each follow REQ-013 with no interaction.
REQ-017 On each cycle with T_valid=1, T_raw SHALL be added to a 9-bit accumulator and a 2-bit sample counter SHALL increment.
REQ-018 On the T_valid cycle that carries the 4th sample (counter==3), at the next edge:
- ST SHALL load (accumulator + T_raw) >> 2, truncated.
- temp_upd SHALL be 1 for exactly one cycle.
- The accumulator and the counter SHALL clear (the counter wraps 3->0).
REQ-019 ST SHALL hold its value between updates. T_raw SHALL be ignored when T_valid=0.
REQ-020 Accumulator width SHALL be 9 bits: the sum of 4 x 127 = 508, so no overflow is possible.
REQ-021 temp_upd SHALL be 0 on every cycle except the one defined in REQ-018.

Reset
REQ-022 When Rst_n=0, all state SHALL clear asynchronously:
- synchronisers, stable levels, counters and accumulator = 0;
- SFD=SRD=SW=SFA=0;
- ST=TEMP_INIT;
- temp_upd=0.
REQ-023 Reset asserted mid-debounce or mid-average SHALL discard the partial count or sum. After release, filtering SHALL restart from the first new sample.
REQ-024 Deassertion SHALL take effect at the first clk edge after Rst_n rises.

Structure
REQ-025 A shared package SHALL hold the DEBOUNCE_CYCLES default, TEMP_INIT, the average depth constant (4) and the accumulator width.
REQ-026 One sub-module, debounce_cell (synchroniser + counter + stable level), SHALL be instantiated four times. Temperature averaging SHALL stay in the top level.

Verification
REQ-027 raw_SFD 0->1 held, default parameters -> SFD=0 through edge n+8, SFD=1 at edge n+9.
REQ-028 raw_SW high for 5 cycles, then low -> SW remains 0 throughout. A following 12-cycle high -> SW=1 at the 9th edge after the first sampled high.
REQ-029 T_valid with T_raw = 20, 21, 22, 25 -> ST=22 (88>>2) and temp_upd=1 for one cycle, one edge after the 4th strobe. Then T_raw = 127 x4 -> ST=127.
REQ-030 T_raw=30 x3, then Rst_n pulsed low, then 40 x4 -> ST=TEMP_INIT during and after reset, then ST=40 with no contribution from 30.
REQ-031 raw_SFA and raw_SRD rise on the same edge while raw_SFD glitches for 3 cycles -> SFA=1 and SRD=1 on the same edge, SFD stays 0.
REQ-032 Rst_n asserted asynchronously between clk edges with all outputs at 1 -> outputs clear immediately without a clk edge, ST=TEMP_INIT.
